// File: rtl/pes_usr_pkg.sv
// Shared types for the sequenced universal shift register: mode codes,
// FSM states and mode classification helpers.
package pes_usr_pkg;

  localparam int unsigned MODE_W = 3;

  typedef enum logic [MODE_W-1:0] {
    MODE_HOLD = 3'b000,
    MODE_SHR  = 3'b001,
    MODE_SHL  = 3'b010,
    MODE_LOAD = 3'b011,
    MODE_ROR  = 3'b100,
    MODE_ROL  = 3'b101,
    MODE_ASR  = 3'b110,
    MODE_CLR  = 3'b111
  } mode_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // Modes that move bits one position per step and honour the shift count.
  function automatic logic is_shift(input mode_e m);
    return (m == MODE_SHR) || (m == MODE_SHL) || (m == MODE_ROR) ||
           (m == MODE_ROL) || (m == MODE_ASR);
  endfunction

endpackage

// File: rtl/pes_usr_step.sv
// Combinational single-bit step of the shifter; shared by the first step
// issued from IDLE and every step taken in SHIFT.
module pes_usr_step
  import pes_usr_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] q_i,
  input  mode_e            mode_i,
  input  logic             sin_l_i,
  input  logic             sin_r_i,
  output logic [WIDTH-1:0] next_q_c_o,
  output logic             out_bit_c_o
);

  always_comb begin
    next_q_c_o  = q_i;
    out_bit_c_o = 1'b0;
    case (mode_i)
      MODE_SHR: begin
        next_q_c_o  = {sin_l_i, q_i[WIDTH-1:1]};
        out_bit_c_o = q_i[0];
      end
      MODE_SHL: begin
        next_q_c_o  = {q_i[WIDTH-2:0], sin_r_i};
        out_bit_c_o = q_i[WIDTH-1];
      end
      MODE_ROR: begin
        next_q_c_o  = {q_i[0], q_i[WIDTH-1:1]};
        out_bit_c_o = q_i[0];
      end
      MODE_ROL: begin
        next_q_c_o  = {q_i[WIDTH-2:0], q_i[WIDTH-1]};
        out_bit_c_o = q_i[WIDTH-1];
      end
      MODE_ASR: begin
        next_q_c_o  = {q_i[WIDTH-1], q_i[WIDTH-1:1]};
        out_bit_c_o = q_i[0];
      end
      default: begin
        next_q_c_o  = q_i;
        out_bit_c_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/pes_usr_seq.sv
// Parametrised universal shift register; multi-bit shifts run one bit per
// clock under start/busy/done. Optional status outputs under USR_STATUS_EN.
module pes_usr_seq
  import pes_usr_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AMT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] in,
  input  logic [AMT_W-1:0] amt,
  input  logic             sin_l,
  input  logic             sin_r,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic             busy,
`ifdef USR_STATUS_EN
  output logic             zero,
  output logic [AMT_W-1:0] ones,
`endif
  output logic             done
);

  state_e           state_q, state_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  mode_e            mode_q, mode_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             sout_q, sout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  mode_e            mode_in;
  logic [AMT_W-1:0] amt_sat;
  logic             accept;
  logic             first_step;
  mode_e            step_mode;
  logic [WIDTH-1:0] step_q;
  logic             step_bit;

  assign mode_in    = mode_e'(mode);
  assign amt_sat    = (amt > AMT_W'(WIDTH)) ? AMT_W'(WIDTH) : amt;
  assign accept     = (state_q == ST_IDLE) && start;
  assign first_step = accept && is_shift(mode_in) && (amt_sat != '0);
  assign step_mode  = (state_q == ST_IDLE) ? mode_in : mode_q;

  pes_usr_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .q_i        (q_q),
    .mode_i     (step_mode),
    .sin_l_i    (sin_l),
    .sin_r_i    (sin_r),
    .next_q_c_o (step_q),
    .out_bit_c_o(step_bit)
  );

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      mode_q  <= MODE_HOLD;
      q_q     <= '0;
      sout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      q_q     <= q_d;
      sout_q  <= sout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state: the first step happens at the accepting edge, so the
  // counter holds the steps still owed after it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    case (state_q)
      ST_IDLE: begin
        if (first_step) begin
          mode_d = mode_in;
          cnt_d  = amt_sat - AMT_W'(1);
          if (amt_sat > AMT_W'(1)) begin
            state_d = ST_SHIFT;
          end
        end
      end
      ST_SHIFT: begin
        cnt_d = cnt_q - AMT_W'(1);
        if (cnt_q == AMT_W'(1)) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath and handshake outputs.
  always_comb begin
    q_d    = q_q;
    sout_d = sout_q;
    done_d = 1'b0;
    busy_d = (state_d == ST_SHIFT);
    if ((state_q == ST_SHIFT) || first_step) begin
      q_d    = step_q;
      sout_d = step_bit;
    end
    if (accept) begin
      if (mode_in == MODE_LOAD) begin
        q_d = in;
      end else if (mode_in == MODE_CLR) begin
        q_d = '0;
      end
      if (!(is_shift(mode_in) && (amt_sat > AMT_W'(1)))) begin
        done_d = 1'b1;
      end
    end
    if ((state_q == ST_SHIFT) && (cnt_q == AMT_W'(1))) begin
      done_d = 1'b1;
    end
  end

  assign q    = q_q;
  assign sout = sout_q;
  assign busy = busy_q;
  assign done = done_q;

`ifdef USR_STATUS_EN
  logic             zero_q, zero_d;
  logic [AMT_W-1:0] ones_q, ones_d;

  // Status flags track the value q takes at the same edge.
  always_comb begin
    zero_d = (q_d == '0);
    ones_d = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      ones_d = ones_d + AMT_W'(q_d[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zero_q <= 1'b1;
      ones_q <= '0;
    end else begin
      zero_q <= zero_d;
      ones_q <= ones_d;
    end
  end

  assign zero = zero_q;
  assign ones = ones_q;
`endif

endmodule

// File: tb/tb_pes_usr_seq.sv
// Scoreboard bench for pes_usr_seq: directed cases then randomized ops
// checked against an arithmetic reference model.
module tb_pes_usr_seq;
  import pes_usr_pkg::*;

  localparam int unsigned W  = 8;
  localparam int unsigned AW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [2:0]    mode = 3'b000;
  logic [W-1:0]  din = '0;
  logic [AW-1:0] amt = '0;
  logic          sin_l = 1'b0;
  logic          sin_r = 1'b0;
  logic [W-1:0]  q;
  logic          sout;
  logic          busy;
  logic          done;
`ifdef USR_STATUS_EN
  logic          zero;
  logic [AW-1:0] ones;
`endif

  pes_usr_seq #(.WIDTH(W), .AMT_W(AW)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .mode (mode),
    .in   (din),
    .amt  (amt),
    .sin_l(sin_l),
    .sin_r(sin_r),
    .q    (q),
    .sout (sout),
    .busy (busy),
`ifdef USR_STATUS_EN
    .zero (zero),
    .ones (ones),
`endif
    .done (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] q;
    logic         sout;
  } exp_t;

  exp_t         sb[$];
  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] mq = '0;
  logic         msout = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference: the whole N-step op computed in one go with plain arithmetic.
  function automatic int model_op(input mode_e m, input logic [W-1:0] d, input int a,
                                  input logic sl, input logic sr);
    int           n;
    int           k;
    logic [W-1:0] all1;
    logic [W-1:0] fill;
    n    = (a > int'(W)) ? int'(W) : a;
    k    = n % int'(W);
    all1 = '1;
    case (m)
      MODE_LOAD: mq = d;
      MODE_CLR:  mq = '0;
      MODE_SHR, MODE_ASR: if (n > 0) begin
        fill  = (m == MODE_ASR) ? {W{mq[W-1]}} : {W{sl}};
        msout = mq[n-1];
        mq    = (mq >> n) | (fill & ~(all1 >> n));
      end
      MODE_SHL: if (n > 0) begin
        msout = mq[int'(W)-n];
        mq    = (mq << n) | ({W{sr}} & ~(all1 << n));
      end
      MODE_ROR: if (n > 0) begin
        msout = mq[(n-1) % int'(W)];
        mq    = (mq >> k) | (mq << (int'(W) - k));
      end
      MODE_ROL: if (n > 0) begin
        msout = mq[(int'(W) - k) % int'(W)];
        mq    = (mq << k) | (mq >> (int'(W) - k));
      end
      default: ;
    endcase
    return (is_shift(m) && n >= 2) ? n - 1 : 0;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=1 required=0");
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("done_q", 32'(q), 32'(e.q));
        check("done_sout", 32'(sout), 32'(e.sout));
      end
    end
  end

  // Issue one op at a negedge; return at the negedge where done is visible.
  task automatic issue(input mode_e m, input logic [W-1:0] d, input int a,
                       input logic sl, input logic sr, input bit inject);
    int lat;
    mode  = m;
    din   = d;
    amt   = AW'(a);
    sin_l = sl;
    sin_r = sr;
    start = 1'b1;
    lat   = model_op(m, d, a, sl, sr);
    sb.push_back('{q: mq, sout: msout});
    @(negedge clk);
    for (int i = 0; i < lat; i++) begin
      check("busy_high", 32'(busy), 32'd1);
      if (inject) begin
        start = 1'b1;
        mode  = MODE_LOAD;
        din   = W'($urandom);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check("busy_low_at_done", 32'(busy), 32'd0);
  endtask

  task automatic idle(input int n);
    start = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int dones;
    repeat (2) @(negedge clk);
    check("rst_q", 32'(q), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sout", 32'(sout), 32'd0);
`ifdef USR_STATUS_EN
    check("rst_zero", 32'(zero), 32'd1);
    check("rst_ones", 32'(ones), 32'd0);
`endif
    rst = 1'b0;
    @(negedge clk);

    issue(MODE_LOAD, 8'hC5, 0, 1'b0, 1'b0, 1'b0);
    check("load_c5", 32'(q), 32'hC5);
    issue(MODE_SHR, 8'h00, 3, 1'b1, 1'b0, 1'b0);
    check("shr3_q", 32'(q), 32'hF8);
    check("shr3_sout", 32'(sout), 32'd1);
    issue(MODE_LOAD, 8'hC5, 0, 1'b0, 1'b0, 1'b0);
    issue(MODE_ASR, 8'h00, 1, 1'b0, 1'b0, 1'b0);
    check("asr1_q", 32'(q), 32'hE2);
    issue(MODE_LOAD, 8'h81, 0, 1'b0, 1'b0, 1'b0);
    issue(MODE_ROL, 8'h00, 8, 1'b0, 1'b0, 1'b0);
    check("rol8_q", 32'(q), 32'h81);
    issue(MODE_ROR, 8'h00, 1, 1'b0, 1'b0, 1'b0);
    check("ror1_q", 32'(q), 32'hC0);
    check("ror1_sout", 32'(sout), 32'd1);
    issue(MODE_LOAD, 8'h0F, 0, 1'b0, 1'b0, 1'b0);
    issue(MODE_SHL, 8'h00, 4, 1'b0, 1'b0, 1'b1);
    check("shl4_ignore_load", 32'(q), 32'hF0);
    issue(MODE_SHL, 8'h00, 0, 1'b1, 1'b1, 1'b0);
    check("shl0_q", 32'(q), 32'hF0);
    issue(MODE_LOAD, 8'hA5, 0, 1'b0, 1'b0, 1'b0);
    issue(MODE_SHL, 8'h00, 12, 1'b0, 1'b0, 1'b0);
    check("shl12_q", 32'(q), 32'h00);

    // Reset in the middle of a rotate aborts with no done.
    issue(MODE_LOAD, 8'h01, 0, 1'b0, 1'b0, 1'b0);
    idle(1);
`ifdef USR_STATUS_EN
    check("load1_zero", 32'(zero), 32'd0);
    check("load1_ones", 32'(ones), 32'd1);
`endif
    mode  = MODE_ROR;
    amt   = AW'(6);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_q", 32'(q), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    @(negedge clk);
    rst   = 1'b0;
    mq    = '0;
    msout = 1'b0;
    dones = 0;
    repeat (8) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    check("abort_no_done", 32'(dones), 32'd0);

    for (int t = 0; t < 300; t++) begin
      issue(mode_e'(3'($urandom_range(0, 7))), W'($urandom), int'($urandom_range(0, 15)),
            1'($urandom), 1'($urandom), 1'($urandom));
      idle(int'($urandom_range(0, 2)));
    end

    idle(4);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pes_usr_seq.md
Name: pes_usr_seq

Overview:
Parametrised successor to the 4-bit universal shift register.
- Configurable width.
- 3-bit mode with rotate, arithmetic and clear ops.
- Multi-bit shifts sequenced one bit per clock under a start/busy/done handshake.
- Serial in/out on both ends.
- Sits in the datapath as a register-file-style shifter driven by a small controller.

Parameters:
WIDTH, 8, data width in bits (≥2)
AMT_W, $clog2(WIDTH)+1, width of shift-amount input (covers 0..WIDTH)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous active-high reset
start  input  1  issue operation; sampled only when not busy
mode  input  3  operation code, sampled with start
in  input  WIDTH  parallel load data, sampled with start
amt  input  AMT_W  shift count for shift/rotate modes, sampled with start
sin_l  input  1  serial fill for MSB (logical shift right)
sin_r  input  1  serial fill for LSB (shift left)
q  output  WIDTH  register contents
sout  output  1  last bit shifted/rotated out (registered)
busy  output  1  multi-cycle op in progress
done  output  1  one-cycle completion pulse

Behaviour:
- Reset values (async, immediate): q=0, sout=0, busy=0, done=0, FSM=IDLE, counter=0.
- Modes:
  - 000 hold
  - 001 SHR (MSB←sin_l)
  - 010 SHL (LSB←sin_r)
  - 011 LOAD (q←in)
  - 100 ROR
  - 101 ROL
  - 110 ASR (MSB replicated)
  - 111 CLEAR (q←0)
- FSM states: IDLE, SHIFT. DONE is not a state; done is a registered flag.
- IDLE + start=1:
  - HOLD/LOAD/CLEAR: act at that edge. done=1 for the next cycle. Stay IDLE.
  - Shift/rotate with amt=N≥1: first one-bit step at that edge. Latch mode; counter←N-1.
    - N=1: stay IDLE, done next cycle.
    - N>1: go to SHIFT, busy=1.
  - Shift/rotate with amt=0: q and sout unchanged, done pulse next cycle.
  - amt>WIDTH: saturate to WIDTH.
- SHIFT state:
  - Each edge performs one step and decrements the counter.
  - The edge taking the counter 1→0 returns to IDLE. busy drops and done=1 in the following cycle.
- start while busy is ignored: no queueing, no error.
- sin_l/sin_r are sampled live at every step edge, not latched at start.
- sout updates only on shift/rotate steps:
  - Right ops: sout←q[0].
  - Left ops: sout←q[WIDTH-1].
- done is high exactly one cycle per accepted start. start may be reasserted in the same cycle done is high and is accepted.
- Reset mid-operation aborts immediately. No done is produced for the aborted op.
- N steps of a rotate equal rotate-by-N mod WIDTH. amt=WIDTH rotate restores q.

Optional Feature:
USR_STATUS_EN
- Defined: adds output zero (1 bit) = registered (q==0), updated on every edge q may change. Reset value 1. Also adds output ones (AMT_W bits) = registered popcount of q. Reset value 0.
- Undefined: ports and logic are absent. Core behaviour is identical.

Decomposition:
- Package pes_usr_pkg:
  - mode localparams/enum MODE_HOLD..MODE_CLR.
  - FSM state enum {ST_IDLE, ST_SHIFT}.
  - Function is_shift(mode).
- Sub-module pes_usr_step: combinational single-bit step.
  - Inputs: q, mode, sin_l, sin_r.
  - Outputs: next_q, out_bit.
  - Reused for the first step and the SHIFT-state steps.

Test Plan:
- Reset/LOAD:
  - rst=1 → q=0, busy=0, done=0.
  - Release; start LOAD in=8'hC5 → q=C5 next edge, done pulse 1 cycle, busy never high.
- SHR/ASR:
  - q=C5, SHR amt=3, sin_l=1 → q=F8 after 3 edges, busy 2 cycles, sout=1.
  - From C5, ASR amt=1 → E2, sout=1.
- Rotate wrap:
  - q=81, ROL amt=8 → q=81, busy 7 cycles, single done.
  - ROR amt=1 → C0, sout=1.
- Handshake:
  - start SHL amt=4 on q=0F, sin_r=0; during busy issue LOAD in=FF → ignored, q=F0.
  - Back-to-back start in the done cycle is accepted.
- amt edges:
  - amt=0 SHL → q unchanged, done pulse.
  - amt=12 with WIDTH=8 → behaves as 8; SHL gives q=00.
- Reset mid-op: ROR amt=6 on q=01, assert rst after 2 steps → q=0, busy=0, no done afterwards.
- With USR_STATUS_EN: zero=1 after reset, zero=0 after LOAD 01, ones=1.
